// File: rtl/fft_bfly_sched.sv
// Butterfly sequencer for an in-place radix-2 DIF FFT.
// Walks every stage and butterfly of an N = 2^L transform. Each butterfly's
// address pair and twiddle index go to the datapath over valid/ready. Drain
// bubbles follow each stage so that write-back finishes before the next
// stage reads.
module fft_bfly_sched #(
  parameter int MAX_LOG2N = 12,
  parameter int PIPE_LAT  = 3
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [3:0]           cfg_log2n,
  input  logic                 abort,
  input  logic                 bfly_ready,
  output logic                 bfly_valid,
  output logic [MAX_LOG2N-1:0] addr_a,
  output logic [MAX_LOG2N-1:0] addr_b,
  output logic [MAX_LOG2N-2:0] tw_idx,
  output logic [3:0]           stage,
  output logic                 last_bfly,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int AW = MAX_LOG2N;
  localparam int JW = MAX_LOG2N - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int DL = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
  localparam logic [DW-1:0] DRAIN_LAST = DL[DW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    l_q, l_d;
  logic [3:0]    s_q, s_d;
  logic [JW-1:0] j_q, j_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          cfg_err_d;

  // Index of the final butterfly in a stage: N/2 - 1.
  function automatic logic [JW-1:0] last_j(input logic [3:0] l);
    logic [JW-1:0] ones;
    ones = '1;
    return ones >> (4'(AW) - l);
  endfunction

  // Upper-leg address: the high bits of j move up one position to open a
  // gap of width 'half'. The low bits stay within the butterfly group.
  function automatic logic [AW-1:0] calc_addr(input logic [3:0] l, input logic [3:0] s,
                                              input logic [JW-1:0] j);
    logic [3:0]    sh;
    logic [AW-1:0] jx;
    logic [AW-1:0] mask;
    sh   = l - 4'd1 - s;
    jx   = AW'(j);
    mask = (AW'(1) << sh) - AW'(1);
    return ((jx >> sh) << (sh + 4'd1)) | (jx & mask);
  endfunction

  // Distance between legs at stage s: N >> (s+1).
  function automatic logic [AW-1:0] calc_half(input logic [3:0] l, input logic [3:0] s);
    return AW'(1) << (l - 4'd1 - s);
  endfunction

  // Twiddle index: offset within the group, scaled by 2^s.
  function automatic logic [JW-1:0] calc_tw(input logic [3:0] l, input logic [3:0] s,
                                            input logic [JW-1:0] j);
    logic [AW-1:0] mask;
    mask = calc_half(l, s) - AW'(1);
    return JW'((AW'(j) & mask) << s);
  endfunction

  logic hs;
  logic last_stage;
  logic last_j_hit;
  assign hs         = bfly_valid & bfly_ready;
  assign last_stage = (s_q == l_q - 4'd1);
  assign last_j_hit = (j_q == last_j(l_q));

  // Next-state sequencing of the stage, butterfly and drain counters.
  always_comb begin
    state_d   = state_q;
    l_d       = l_q;
    s_d       = s_q;
    j_d       = j_q;
    drain_d   = drain_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_log2n != 4'd0 && int'(cfg_log2n) <= MAX_LOG2N) begin
            state_d = S_RUN;
            l_d     = cfg_log2n;
            s_d     = '0;
            j_d     = '0;
            drain_d = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          s_d     = '0;
          j_d     = '0;
          drain_d = '0;
        end else if (hs) begin
          if (last_j_hit) begin
            if (PIPE_LAT > 0) begin
              state_d = S_DRAIN;
              drain_d = '0;
            end else if (last_stage) begin
              state_d = S_FIN;
            end else begin
              s_d = s_q + 4'd1;
              j_d = '0;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
          s_d     = '0;
          j_d     = '0;
          drain_d = '0;
        end else if (drain_q == DRAIN_LAST) begin
          drain_d = '0;
          if (last_stage) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RUN;
            s_d     = s_q + 4'd1;
            j_d     = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        s_d     = '0;
        j_d     = '0;
        drain_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic run_d;
  logic busy_d;
  assign run_d  = (state_d == S_RUN);
  assign busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);

  // State, counters and all outputs registered from next-state values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      l_q        <= '0;
      s_q        <= '0;
      j_q        <= '0;
      drain_q    <= '0;
      bfly_valid <= 1'b0;
      addr_a     <= '0;
      addr_b     <= '0;
      tw_idx     <= '0;
      stage      <= '0;
      last_bfly  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_q        <= l_d;
      s_q        <= s_d;
      j_q        <= j_d;
      drain_q    <= drain_d;
      bfly_valid <= run_d;
      addr_a     <= run_d ? calc_addr(l_d, s_d, j_d) : '0;
      addr_b     <= run_d ? (calc_addr(l_d, s_d, j_d) | calc_half(l_d, s_d)) : '0;
      tw_idx     <= run_d ? calc_tw(l_d, s_d, j_d) : '0;
      stage      <= busy_d ? s_d : 4'd0;
      last_bfly  <= run_d && (s_d == l_d - 4'd1) && (j_d == last_j(l_d));
      busy       <= busy_d;
      done       <= (state_d == S_FIN);
      cfg_err    <= cfg_err_d;
    end
  end

endmodule
